// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
`timescale 1ns/1ps

module uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_dat,
   input  logic             in_val,
   output logic             in_rdy,
   output logic             tx,
   output logic             busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state;
   logic [CW-1:0]    cyc_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] shift_next;
`ifdef UART_TX_PARITY_EN
   logic             parity;
`endif

   assign shift_next = shift >> 1;

   // bit_cnt counts data bits in DATA and is reused to count stop bits in STOP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= 1'b1;
         in_rdy  <= 1'b0;
         busy    <= 1'b0;
         cyc_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
`ifdef UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx      <= 1'b1;
               busy    <= 1'b0;
               cyc_cnt <= '0;
               bit_cnt <= '0;
               if (in_rdy && in_val) begin
                  shift  <= in_dat;
`ifdef UART_TX_PARITY_EN
                  parity <= ^in_dat;
`endif
                  in_rdy <= 1'b0;
                  busy   <= 1'b1;
                  tx     <= 1'b0;
                  state  <= START;
               end else begin
                  in_rdy <= 1'b1;
               end
            end

            START: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end

            DATA: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  shift   <= shift_next;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= parity;
                     state   <= PARITY;
`else
                     tx      <= 1'b1;
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     tx      <= shift_next[0];
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  tx      <= 1'b1;
                  state   <= STOP;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
`endif

            STOP: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     in_rdy  <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-position reference model, line decoder and directed/random traffic.
`timescale 1ns/1ps

module tb_uart_tx;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int F = (1 + W + PB + SB) * C;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_dat;
   logic         in_val;
   logic         in_rdy;
   logic         tx;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cycle    = 0;
   bit mon_en   = 0;

   uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
      .clk    (clk),
      .rst    (rst),
      .in_dat (in_dat),
      .in_val (in_val),
      .in_rdy (in_rdy),
      .tx     (tx),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference model: tracks cycles since the accept edge; the line level follows from the frame layout
   bit           m_active = 0;
   bit           m_rdy    = 0;
   int           m_pos    = 0;
   logic [W-1:0] m_word   = '0;
   logic [W-1:0] exp_q[$];

   function automatic logic exp_line(input int pos, input logic [W-1:0] w);
      int b;
      b = pos / C;
      if (b == 0) return 1'b0;
      if (b <= W) return w[b-1];
      if (PB == 1 && b == W + 1) return ^w;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         if (m_active) void'(exp_q.pop_back());
         m_active = 0;
         m_rdy    = 0;
         m_pos    = 0;
      end else if (m_active) begin
         m_pos++;
         if (m_pos == F) begin
            m_active = 0;
            m_rdy    = 1;
         end
      end else if (m_rdy && in_val) begin
         m_active = 1;
         m_pos    = 0;
         m_word   = in_dat;
         m_rdy    = 0;
         exp_q.push_back(in_dat);
      end else begin
         m_rdy = 1;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("tx", {31'd0, tx}, {31'd0, m_active ? exp_line(m_pos, m_word) : 1'b1});
         checkOutput("busy", {31'd0, busy}, {31'd0, m_active});
         checkOutput("in_rdy", {31'd0, in_rdy}, {31'd0, m_rdy});
      end
   end

   // Line decoder: samples mid-bit after a falling start edge and matches words against the accept order
   bit           dec_on = 0;
   int           dec_cnt = 0;
   int           dec_words = 0;
   logic [W-1:0] dec_word = '0;

   always @(negedge clk) begin
      if (rst) begin
         dec_on = 0;
      end else if (mon_en) begin
         if (!dec_on) begin
            if (tx === 1'b0) begin
               dec_on  = 1;
               dec_cnt = 0;
            end
         end else begin
            dec_cnt++;
            if (dec_cnt % C == C / 2) begin
               int b;
               b = dec_cnt / C;
               if (b >= 1 && b <= W) begin
                  dec_word[b-1] = tx;
`ifdef UART_TX_PARITY_EN
               end else if (b == W + 1) begin
                  checkOutput("dec_parity", {31'd0, tx},
                              {31'd0, (exp_q.size() > 0) ? ^exp_q[0] : 1'b0});
`endif
               end else if (b == W + 1 + PB) begin
                  checkOutput("dec_stop", {31'd0, tx}, 32'd1);
                  if (exp_q.size() == 0) checkOutput("dec_extra", 32'd1, 32'd0);
                  else checkOutput("dec_word", {24'd0, dec_word}, {24'd0, exp_q.pop_front()});
                  dec_words++;
                  dec_on = 0;
               end
            end
         end
      end
   end

   // Called at a negedge; returns the cycle number of the accept edge, or -1 on timeout
   task automatic applyStimulus(input logic [W-1:0] word, input bit hold, output int acc_cyc);
      int budget;
      in_val = 1'b1;
      in_dat = word;
      budget = 0;
      while (in_rdy !== 1'b1 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         in_val  = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cycle;
      @(negedge clk);
      if (!hold) begin
         in_val = 1'b0;
         in_dat = W'($urandom);
      end
   endtask

   task automatic waitReady(input int acc_cyc, input string tag);
      int budget;
      budget = 0;
      while (in_rdy !== 1'b1 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      checkOutput(tag, cycle - acc_cyc, F);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a, b, n_acc;
      bit hold;
      rst    = 1'b1;
      in_val = 1'b0;
      in_dat = '0;
      n_acc  = 0;
      @(posedge clk);
      #1;
      mon_en = 1;

      repeat (5) @(negedge clk);
      checkOutput("rst_tx", {31'd0, tx}, 32'd1);
      checkOutput("rst_rdy", {31'd0, in_rdy}, 32'd0);
      rst = 1'b0;
      checkOutput("rdy_pre_edge", {31'd0, in_rdy}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rdy_first_edge", {31'd0, in_rdy}, 32'd1);
      @(negedge clk);

      applyStimulus(8'h55, 0, a); n_acc++;
      waitReady(a, "rdy_return_55");

      applyStimulus(8'hA5, 1, a); n_acc++;
      applyStimulus(8'h3C, 0, b); n_acc++;
      checkOutput("b2b_spacing", b - a, F + 1);
      waitReady(b, "rdy_return_3c");

      applyStimulus(8'h5A, 0, a); n_acc++;
      repeat (10) @(negedge clk);
      applyStimulus(8'hC3, 0, b); n_acc++;
      checkOutput("bp_spacing", b - a, F + 1);
      waitReady(b, "rdy_return_c3");

      // Abort mid data bit 3 (line low for 0xF0) and confirm an immediate return to idle
      applyStimulus(8'hF0, 0, a);
      repeat (17) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort_tx", {31'd0, tx}, 32'd1);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_rdy", {31'd0, in_rdy}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(8'hFF, 0, a); n_acc++;
      waitReady(a, "rdy_return_ff");

`ifdef UART_TX_PARITY_EN
      applyStimulus(8'h07, 0, a); n_acc++;
      waitReady(a, "rdy_return_07");
      applyStimulus(8'h03, 0, a); n_acc++;
      waitReady(a, "rdy_return_03");
`endif

      hold = 0;
      for (int i = 0; i < 20; i++) begin
         if (!hold) begin
            repeat ($urandom_range(0, 3)) begin
               in_dat = W'($urandom);
               @(negedge clk);
            end
         end
         hold = 1'($urandom_range(0, 1));
         applyStimulus(W'($urandom), hold, a); n_acc++;
      end
      in_val = 1'b0;
      waitReady(a, "rdy_return_last");
      repeat (F + 5) @(negedge clk);

      checkOutput("queue_empty", exp_q.size(), 32'd0);
      checkOutput("decoded_count", dec_words, n_acc);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
